// File: rtl/cache_axi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_pkg
// Description : Shared encodings for the cache-side AXI read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_axi_pkg;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam int LINE_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } owner_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/cache_axi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_arbiter_if
// Description : Cache request/return and bridge read/write signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_axi_arbiter_if;
    logic         i_rd_req;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         i_rd_rdy;
    logic         i_ret_valid;
    logic         i_ret_last;
    logic [31:0]  i_ret_data;

    logic         d_rd_req;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic         d_rd_rdy;
    logic         d_ret_valid;
    logic         d_ret_last;
    logic [31:0]  d_ret_data;

    logic         d_wr_req;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;

    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;

    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    logic         err_spurious;

    // Arbiter view
    modport slave (
        input  i_rd_req, i_rd_type, i_rd_addr,
        output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        input  d_rd_req, d_rd_type, d_rd_addr,
        output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        output d_wr_rdy,
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  wr_rdy,
        output err_spurious
    );

    // Caches + bridge view
    modport master (
        output i_rd_req, i_rd_type, i_rd_addr,
        input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        output d_rd_req, d_rd_type, d_rd_addr,
        input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        input  d_wr_rdy,
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output wr_rdy,
        input  err_spurious
    );
endinterface
`default_nettype wire

// File: rtl/cache_axi_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way icache/dcache selector, round-robin or dcache-first.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import cache_axi_pkg::*;
#(
    parameter int DPRIO = 0
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_req_ic,
    input  wire logic i_req_dc,
    input  wire logic i_advance,
    output grant_e    o_sel
);

    grant_e r_last_grant;

    // On a tie the side that did not win last time goes next, unless dcache is pinned
    always_comb begin
        o_sel = GRANT_I;
        if (i_req_dc && (!i_req_ic || (DPRIO != 0) || (r_last_grant == GRANT_I)))
            o_sel = GRANT_D;
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_last_grant <= GRANT_D;
        else if (i_advance)
            r_last_grant <= o_sel;
    end

endmodule
`default_nettype wire

// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_arbiter
// Description : Shares the bridge read port between icache and dcache and
//               routes return beats to the owning cache; writes pass through.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_axi_arbiter
    import cache_axi_pkg::*;
#(
    parameter int DPRIO  = 0,
    parameter int BEAT_W = 3
) (
    input  wire logic          clock,
    input  wire logic          reset,
    cache_axi_arbiter_if.slave bus
);

    localparam logic [BEAT_W-1:0] C_BEAT_MAX = '1;

    owner_e            r_state;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_err;

    logic   w_owned;
    logic   w_burst_end;
    logic   w_can_grant;
    logic   w_rd_req;
    logic   w_handshake;
    grant_e w_sel;

    assign w_owned     = (r_state != IDLE);
    assign w_burst_end = w_owned && bus.ret_valid && bus.ret_last;
    // Back-to-back: the next burst may be granted on the last beat of the current one
    assign w_can_grant = (r_state == IDLE) || w_burst_end;
    assign w_rd_req    = w_can_grant && (bus.i_rd_req || bus.d_rd_req);
    assign w_handshake = w_rd_req && bus.rd_rdy;

    rr_arb2 #(
        .DPRIO (DPRIO)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .i_req_ic  (bus.i_rd_req),
        .i_req_dc  (bus.d_rd_req),
        .i_advance (w_handshake),
        .o_sel     (w_sel)
    );

    assign bus.rd_req = w_rd_req;

    always_comb begin
        bus.rd_type = 3'b000;
        bus.rd_addr = 32'h0;
        if (w_rd_req) begin
            if (w_sel == GRANT_D) begin
                bus.rd_type = bus.d_rd_type;
                bus.rd_addr = bus.d_rd_addr;
            end else begin
                bus.rd_type = bus.i_rd_type;
                bus.rd_addr = bus.i_rd_addr;
            end
        end
    end

    assign bus.i_rd_rdy = w_handshake && (w_sel == GRANT_I);
    assign bus.d_rd_rdy = w_handshake && (w_sel == GRANT_D);

    assign bus.i_ret_valid = (r_state == OWN_I) && bus.ret_valid;
    assign bus.i_ret_last  = (r_state == OWN_I) && bus.ret_last;
    assign bus.d_ret_valid = (r_state == OWN_D) && bus.ret_valid;
    assign bus.d_ret_last  = (r_state == OWN_D) && bus.ret_last;
    assign bus.i_ret_data  = bus.ret_data;
    assign bus.d_ret_data  = bus.ret_data;

    assign bus.wr_req   = bus.d_wr_req;
    assign bus.wr_type  = bus.d_wr_type;
    assign bus.wr_addr  = bus.d_wr_addr;
    assign bus.wr_wstrb = bus.d_wr_wstrb;
    assign bus.wr_data  = bus.d_wr_data;
    assign bus.d_wr_rdy = bus.wr_rdy;

    assign bus.err_spurious = r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_state    <= (w_sel == GRANT_D) ? OWN_D : OWN_I;
                r_beat_cnt <= '0;
            end else begin
                if (w_burst_end)
                    r_state <= IDLE;
                if (w_owned && bus.ret_valid && (r_beat_cnt != C_BEAT_MAX))
                    r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            // Unowned beats are dropped; a full counter without last means a runaway burst
            if (bus.ret_valid && (!w_owned || ((r_beat_cnt == C_BEAT_MAX) && !bus.ret_last)))
                r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_axi_arbiter
// Description : Directed self-checking bench for cache_axi_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_axi_arbiter;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    cache_axi_arbiter_if bus0 ();
    cache_axi_arbiter_if bus1 ();

    cache_axi_arbiter #(.DPRIO(0), .BEAT_W(3)) u_dut_rr (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    cache_axi_arbiter #(.DPRIO(1), .BEAT_W(3)) u_dut_fp (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic idle0();
        bus0.i_rd_req = 0; bus0.i_rd_type = 0; bus0.i_rd_addr = 0;
        bus0.d_rd_req = 0; bus0.d_rd_type = 0; bus0.d_rd_addr = 0;
        bus0.d_wr_req = 0; bus0.d_wr_type = 0; bus0.d_wr_addr = 0;
        bus0.d_wr_wstrb = 0; bus0.d_wr_data = 0;
        bus0.rd_rdy = 0; bus0.ret_valid = 0; bus0.ret_last = 0;
        bus0.ret_data = 0; bus0.wr_rdy = 0;
    endtask

    task automatic idle1();
        bus1.i_rd_req = 0; bus1.i_rd_type = 0; bus1.i_rd_addr = 0;
        bus1.d_rd_req = 0; bus1.d_rd_type = 0; bus1.d_rd_addr = 0;
        bus1.d_wr_req = 0; bus1.d_wr_type = 0; bus1.d_wr_addr = 0;
        bus1.d_wr_wstrb = 0; bus1.d_wr_data = 0;
        bus1.rd_rdy = 0; bus1.ret_valid = 0; bus1.ret_last = 0;
        bus1.ret_data = 0; bus1.wr_rdy = 0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle0();
        idle1();
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        settle();
        check("rst_rd_req",    bus0.rd_req,       0);
        check("rst_i_rd_rdy",  bus0.i_rd_rdy,     0);
        check("rst_d_rd_rdy",  bus0.d_rd_rdy,     0);
        check("rst_i_ret_vld", bus0.i_ret_valid,  0);
        check("rst_d_ret_vld", bus0.d_ret_valid,  0);
        check("rst_err",       bus0.err_spurious, 0);
        check("rst_err_fp",    bus1.err_spurious, 0);

        // icache-only line fill with a concurrent dcache write
        tick();
        bus0.i_rd_req = 1; bus0.i_rd_type = 3'b100; bus0.i_rd_addr = 32'h1C00_0000;
        bus0.rd_rdy = 1;
        settle();
        check("ic_rd_req",   bus0.rd_req,   1);
        check("ic_rd_addr",  bus0.rd_addr,  32'h1C00_0000);
        check("ic_rd_type",  bus0.rd_type,  3'b100);
        check("ic_i_rd_rdy", bus0.i_rd_rdy, 1);
        check("ic_d_rd_rdy", bus0.d_rd_rdy, 0);
        tick();
        bus0.i_rd_req = 0; bus0.i_rd_addr = 0; bus0.rd_rdy = 0;
        bus0.d_wr_req = 1; bus0.d_wr_type = 3'b010; bus0.d_wr_addr = 32'h8000_0010;
        bus0.d_wr_wstrb = 4'b0011; bus0.d_wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        bus0.wr_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            bus0.ret_valid = 1; bus0.ret_data = 32'hA0 + k; bus0.ret_last = (k == 3);
            settle();
            check("ic_beat_i_vld",  bus0.i_ret_valid, 1);
            check("ic_beat_d_vld",  bus0.d_ret_valid, 0);
            check("ic_beat_i_last", bus0.i_ret_last,  (k == 3));
            check("ic_beat_data",   bus0.i_ret_data,  32'hA0 + k);
            if (k == 0) begin
                check("wr_req",   bus0.wr_req,   1);
                check("wr_addr",  bus0.wr_addr,  32'h8000_0010);
                check("wr_wstrb", bus0.wr_wstrb, 4'b0011);
                check("wr_type",  bus0.wr_type,  3'b010);
                check("wr_data",  bus0.wr_data,  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
                check("d_wr_rdy", bus0.d_wr_rdy, 1);
                check("ic_no_rd_req", bus0.rd_req, 0);
            end
        end
        tick();
        bus0.ret_valid = 0; bus0.ret_last = 0;
        bus0.d_wr_req = 0; bus0.wr_rdy = 0;
        bus0.d_rd_req = 1; bus0.d_rd_type = 3'b010; bus0.d_rd_addr = 32'h0000_2000;
        bus0.rd_rdy = 1;
        settle();
        check("post_i_vld",   bus0.i_ret_valid, 0);
        check("post_wr_req",  bus0.wr_req,      0);
        check("idle_rd_req",  bus0.rd_req,      1);
        check("dc_d_rd_rdy",  bus0.d_rd_rdy,    1);
        check("dc_rd_addr",   bus0.rd_addr,     32'h0000_2000);
        tick();
        bus0.d_rd_req = 0; bus0.rd_rdy = 0;
        bus0.ret_valid = 1; bus0.ret_last = 1; bus0.ret_data = 32'hB0;
        settle();
        check("dc_d_vld",  bus0.d_ret_valid, 1);
        check("dc_i_vld",  bus0.i_ret_valid, 0);
        check("dc_d_last", bus0.d_ret_last,  1);
        check("dc_data",   bus0.d_ret_data,  32'hB0);
        tick();
        idle0();

        // Simultaneous requests from reset, round-robin, back-to-back grant
        do_reset();
        bus0.i_rd_req = 1; bus0.i_rd_type = 3'b100; bus0.i_rd_addr = 32'h1C00_0040;
        bus0.d_rd_req = 1; bus0.d_rd_type = 3'b100; bus0.d_rd_addr = 32'h0000_2040;
        bus0.rd_rdy = 1;
        settle();
        check("tie_i_rd_rdy", bus0.i_rd_rdy, 1);
        check("tie_d_rd_rdy", bus0.d_rd_rdy, 0);
        check("tie_rd_addr",  bus0.rd_addr,  32'h1C00_0040);
        tick();
        bus0.i_rd_req = 0; bus0.i_rd_addr = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            bus0.ret_valid = 1; bus0.ret_data = 32'hC0 + k; bus0.ret_last = (k == 3);
            settle();
            if (k < 3) begin
                check("b2b_hold_rd_req", bus0.rd_req,   0);
                check("b2b_hold_d_rdy",  bus0.d_rd_rdy, 0);
            end else begin
                check("b2b_rd_req",  bus0.rd_req,     1);
                check("b2b_d_rdy",   bus0.d_rd_rdy,   1);
                check("b2b_rd_addr", bus0.rd_addr,    32'h0000_2040);
                check("b2b_i_last",  bus0.i_ret_last, 1);
            end
        end
        tick();
        bus0.d_rd_req = 0; bus0.rd_rdy = 0;
        bus0.ret_valid = 1; bus0.ret_last = 1; bus0.ret_data = 32'hD0;
        settle();
        check("b2b_d_vld", bus0.d_ret_valid, 1);
        check("b2b_i_vld", bus0.i_ret_valid, 0);
        tick();
        bus0.ret_valid = 0; bus0.ret_last = 0;

        // Spurious beat in IDLE
        settle();
        check("sp_err_before", bus0.err_spurious, 0);
        tick();
        bus0.ret_valid = 1; bus0.ret_data = 32'hDEAD;
        settle();
        check("sp_i_vld", bus0.i_ret_valid, 0);
        check("sp_d_vld", bus0.d_ret_valid, 0);
        tick();
        bus0.ret_valid = 0;
        settle();
        check("sp_err_set", bus0.err_spurious, 1);
        tick();
        settle();
        check("sp_err_sticky", bus0.err_spurious, 1);

        // Bridge backpressure
        idle0();
        do_reset();
        bus0.i_rd_req = 1; bus0.i_rd_type = 3'b100; bus0.i_rd_addr = 32'h1C00_0080;
        settle();
        check("bp_err_cleared", bus0.err_spurious, 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            settle();
            check("bp_rd_req",   bus0.rd_req,   1);
            check("bp_i_rd_rdy", bus0.i_rd_rdy, 0);
            check("bp_d_rd_rdy", bus0.d_rd_rdy, 0);
            check("bp_rd_addr",  bus0.rd_addr,  32'h1C00_0080);
        end
        tick();
        bus0.rd_rdy = 1;
        settle();
        check("bp_grant", bus0.i_rd_rdy, 1);
        tick();
        bus0.i_rd_req = 0; bus0.rd_rdy = 0;

        // Beat counter overflow: 7 beats fill a 3-bit counter, the 8th without last errors
        for (int k = 0; k < 7; k++) begin
            bus0.ret_valid = 1; bus0.ret_last = 0; bus0.ret_data = 32'hE0 + k;
            settle();
            if (k == 0) check("ovf_i_vld", bus0.i_ret_valid, 1);
            tick();
        end
        bus0.ret_valid = 0;
        settle();
        check("ovf_none_at_7", bus0.err_spurious, 0);
        tick();
        bus0.ret_valid = 1; bus0.ret_last = 0;
        settle();
        tick();
        bus0.ret_valid = 1; bus0.ret_last = 1;
        settle();
        check("ovf_err", bus0.err_spurious, 1);
        check("ovf_last_routed", bus0.i_ret_last, 1);
        tick();
        idle0();

        // Fixed dcache priority
        bus1.i_rd_req = 1; bus1.i_rd_type = 3'b100; bus1.i_rd_addr = 32'h1C00_0100;
        bus1.d_rd_req = 1; bus1.d_rd_type = 3'b100; bus1.d_rd_addr = 32'h0000_3000;
        bus1.rd_rdy = 1;
        for (int r = 0; r < 3; r++) begin
            settle();
            check("fp_d_rd_rdy", bus1.d_rd_rdy, 1);
            check("fp_i_rd_rdy", bus1.i_rd_rdy, 0);
            check("fp_rd_addr",  bus1.rd_addr,  32'h0000_3000);
            if (r > 0) check("fp_d_ret_vld", bus1.d_ret_valid, 1);
            tick();
            bus1.ret_valid = 1; bus1.ret_last = 1; bus1.ret_data = 32'hF0 + r;
        end
        bus1.d_rd_req = 0;
        settle();
        check("fp_i_after_d", bus1.i_rd_rdy, 1);
        check("fp_i_addr",    bus1.rd_addr,  32'h1C00_0100);
        tick();
        idle1();
        settle();
        check("fp_no_err", bus1.err_spurious, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
